// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a length/data/checksum frame into instruction memory, then releases the core
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rstn,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {S_LEN, S_DATA, S_CHK, S_DONE, S_ERR} state_t;

   localparam logic [31:0]     MAX_WORDS = 32'(1) << ADDR_W;
   localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       shift_q, shift_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   widx_q, widx_d;
   logic [31:0]       xor_q, xor_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              cpu_rstn_q, cpu_rstn_d;
   logic [31:0]       word_nxt;
   logic              xfer;

   assign in_ready   = ((state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK)) && !reload;
   assign xfer       = in_valid && in_ready;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_rstn   = cpu_rstn_q;
   assign done       = done_q;
   assign err        = err_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_LEN;
         cnt_q      <= 2'd0;
         shift_q    <= 32'd0;
         len_q      <= '0;
         widx_q     <= '0;
         xor_q      <= 32'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'd0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cpu_rstn_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         len_q      <= len_d;
         widx_q     <= widx_d;
         xor_q      <= xor_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cpu_rstn_q <= cpu_rstn_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      len_d      = len_q;
      widx_d     = widx_q;
      xor_d      = xor_q;
      we_d       = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      err_d      = err_q;
      cpu_rstn_d = cpu_rstn_q;
      // Bytes enter at the top so the first byte ends up in bits 7:0.
      word_nxt   = {in_data, shift_q[31:8]};

      if (reload) begin
         state_d    = S_LEN;
         cnt_d      = 2'd0;
         widx_d     = '0;
         xor_d      = 32'd0;
         done_d     = 1'b0;
         err_d      = 1'b0;
         cpu_rstn_d = 1'b0;
      end else if (xfer) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = word_nxt;
         if (cnt_q == 2'd3) begin
            case (state_q)
               S_LEN: begin
                  len_d  = word_nxt[ADDR_W:0];
                  widx_d = '0;
                  if (word_nxt == 32'd0) begin
                     state_d = S_CHK;
                  end else if (word_nxt > MAX_WORDS) begin
                     state_d    = S_ERR;
                     err_d      = 1'b1;
                     cpu_rstn_d = 1'b0;
                  end else begin
                     state_d = S_DATA;
                  end
               end
               S_DATA: begin
                  we_d    = 1'b1;
                  addr_d  = widx_q[ADDR_W-1:0];
                  wdata_d = word_nxt;
                  xor_d   = xor_q ^ word_nxt;
                  widx_d  = widx_q + IDX_ONE;
                  if (widx_q == len_q - IDX_ONE) begin
                     state_d = S_CHK;
                  end
               end
               S_CHK: begin
                  if (word_nxt == xor_q) begin
                     state_d    = S_DONE;
                     done_d     = 1'b1;
                     cpu_rstn_d = 1'b1;
                  end else begin
                     state_d    = S_ERR;
                     err_d      = 1'b1;
                     cpu_rstn_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'd0;
   logic              reload = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rstn;
   logic              done;
   logic              err;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   int          wr_addr[$];
   logic [31:0] wr_data[$];
   int          wr_cyc[$];
   logic [31:0] fw[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_rstn(cpu_rstn),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr.push_back(int'(imem_addr));
         wr_data.push_back(imem_wdata);
         wr_cyc.push_back(cycle);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int tries = 0;
      bit sent  = 0;
      while (!sent && tries < 400) begin
         @(negedge clk);
         in_data  = b;
         in_valid = ($urandom_range(0, 99) >= gap_pct);
         #1;
         sent = in_valid && in_ready;
         tries++;
         @(posedge clk);
      end
      checks++;
      if (!sent) begin
         failures++;
         $display("FAIL send_byte_timeout: byte %02h accepted=0 required=1", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_pct);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_pct);
   endtask

   // Model: a header above capacity is rejected outright; otherwise every word is written
   // in order from address 0, and the frame succeeds iff the checksum equals the XOR of the words.
   task automatic run_frame(input string name, input logic [31:0] n, input logic [31:0] chk,
                            input int gap_pct, input bit check_spacing);
      int          base = wr_addr.size();
      bit          oversize = (n > 32'(1 << ADDR_W));
      int          exp_n = oversize ? 0 : int'(n);
      logic [31:0] x = 32'd0;
      bit          exp_ok;
      for (int i = 0; i < exp_n; i++) x ^= fw[i];
      exp_ok = !oversize && (chk == x);

      send_word(n, gap_pct);
      if (!oversize) begin
         for (int i = 0; i < exp_n; i++) send_word(fw[i], gap_pct);
         send_word(chk, gap_pct);
      end
      @(negedge clk);
      checks++;
      if (done !== exp_ok) begin
         failures++;
         $display("FAIL %s done: got %b required %b", name, done, exp_ok);
      end
      checks++;
      if (err !== !exp_ok) begin
         failures++;
         $display("FAIL %s err: got %b required %b", name, err, !exp_ok);
      end
      checks++;
      if (cpu_rstn !== exp_ok) begin
         failures++;
         $display("FAIL %s cpu_rstn: got %b required %b", name, cpu_rstn, exp_ok);
      end
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s in_ready_after: got %b required 0", name, in_ready);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      checks++;
      if (wr_addr.size() - base != exp_n) begin
         failures++;
         $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size() - base, exp_n);
      end else begin
         for (int i = 0; i < exp_n; i++) begin
            checks++;
            if (wr_addr[base+i] != i || wr_data[base+i] !== fw[i]) begin
               failures++;
               $display("FAIL %s write[%0d]: got addr %0d data %08h required addr %0d data %08h",
                        name, i, wr_addr[base+i], wr_data[base+i], i, fw[i]);
            end
            if (check_spacing && i > 0) begin
               checks++;
               if (wr_cyc[base+i] - wr_cyc[base+i-1] != 4) begin
                  failures++;
                  $display("FAIL %s spacing[%0d]: got %0d required 4", name, i,
                           wr_cyc[base+i] - wr_cyc[base+i-1]);
               end
            end
         end
      end
      if (exp_n > 0) begin
         checks++;
         if (imem_we !== 1'b0 || int'(imem_addr) != exp_n - 1 || imem_wdata !== fw[exp_n-1]) begin
            failures++;
            $display("FAIL %s hold: got we %b addr %0d data %08h required we 0 addr %0d data %08h",
                     name, imem_we, imem_addr, imem_wdata, exp_n - 1, fw[exp_n-1]);
         end
      end
   endtask

   task automatic do_reload(input string name);
      @(negedge clk);
      reload   = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s reload_ready: got %b required 0", name, in_ready);
      end
      @(negedge clk);
      reload   = 1'b0;
      in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || cpu_rstn !== 1'b0) begin
         failures++;
         $display("FAIL %s after_reload: got rdy %b done %b err %b cpu_rstn %b required 1 0 0 0",
                  name, in_ready, done, err, cpu_rstn);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 ||
          cpu_rstn !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs: got we %b addr %0d data %08h cpu_rstn %b done %b err %b required all 0",
                  imem_we, imem_addr, imem_wdata, cpu_rstn, done, err);
      end
      rstn = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic load_example();
      fw = {};
      fw.push_back(32'h0000_0293);
      fw.push_back(32'h0000_0313);
      fw.push_back(32'hFFFF_F3B7);
   endtask

   task automatic test_good_frame();
      load_example();
      run_frame("good_frame", 32'd3, 32'hFFFF_F237, 0, 1'b1);
   endtask

   task automatic test_bad_checksum();
      load_example();
      run_frame("bad_checksum", 32'd3, 32'd0, 0, 1'b1);
      do_reload("bad_checksum");
   endtask

   task automatic test_empty();
      fw = {};
      run_frame("empty", 32'd0, 32'd0, 0, 1'b0);
   endtask

   task automatic test_oversize();
      fw = {};
      run_frame("oversize", 32'd1025, 32'd0, 0, 1'b0);
   endtask

   task automatic test_full_capacity();
      logic [31:0] x = 32'd0;
      fw = {};
      for (int i = 0; i < 1024; i++) begin
         fw.push_back($urandom);
         x ^= fw[i];
      end
      run_frame("full_capacity", 32'd1024, x, 0, 1'b1);
   endtask

   task automatic test_gaps();
      load_example();
      run_frame("gaps", 32'd3, 32'hFFFF_F237, 50, 1'b0);
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 6; f++) begin
         int          n = $urandom_range(1, 8);
         logic [31:0] x = 32'd0;
         fw = {};
         for (int i = 0; i < n; i++) begin
            fw.push_back($urandom);
            x ^= fw[i];
         end
         if ($urandom_range(0, 1) == 1) x ^= 32'(1) << $urandom_range(0, 31);
         do_reload("random_frames");
         run_frame("random_frames", 32'(n), x, $urandom_range(0, 60), 1'b0);
      end
   endtask

   task automatic test_rstn_mid();
      do_reload("rstn_mid");
      load_example();
      send_word(32'd3, 0);
      send_word(fw[0], 0);
      send_word(fw[1], 0);
      @(negedge clk);
      checks++;
      if (imem_we !== 1'b1 || imem_addr !== 10'd1) begin
         failures++;
         $display("FAIL rstn_mid_second_write: got we %b addr %0d required we 1 addr 1", imem_we, imem_addr);
      end
      in_valid = 1'b0;
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== 32'd0 ||
          cpu_rstn !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
         failures++;
         $display("FAIL rstn_mid_outputs: got we %b addr %0d data %08h cpu_rstn %b done %b err %b required all 0",
                  imem_we, imem_addr, imem_wdata, cpu_rstn, done, err);
      end
      @(negedge clk);
      rstn = 1'b1;
      run_frame("rstn_mid_resend", 32'd3, 32'hFFFF_F237, 0, 1'b1);
   endtask

   task automatic test_reload_mid();
      logic [31:0] x;
      do_reload("reload_mid");
      fw = {};
      send_word(32'd4, 0);
      send_word($urandom, 0);
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      do_reload("reload_mid_data");
      fw.push_back($urandom);
      fw.push_back($urandom);
      x = fw[0] ^ fw[1];
      run_frame("reload_mid_next", 32'd2, x, 30, 1'b0);
   endtask

   initial begin
      test_reset();
      test_good_frame();
      do_reload("after_good");
      test_bad_checksum();
      test_empty();
      do_reload("after_empty");
      test_oversize();
      do_reload("after_oversize");
      test_full_capacity();
      do_reload("after_full");
      test_gaps();
      test_random_frames();
      test_rstn_mid();
      test_reload_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 ADDR_W, 10, imem word-address width; capacity 2^ADDR_W words.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  source has a byte on in_data.
REQ-005 in_data  input  8  stream byte.
REQ-006 in_ready  output  1  loader can take a byte; a transfer occurs on a rising edge with in_valid && in_ready.
REQ-007 reload  input  1  single-cycle request to start a new load.
REQ-008 imem_we  output  1  imem word write strobe, one cycle per word.
REQ-009 imem_addr  output  ADDR_W  imem word address.
REQ-010 imem_wdata  output  32  word to write.
REQ-011 cpu_rstn  output  1  active-low core reset; low until a load completes.
REQ-012 done  output  1  load accepted; core released.
REQ-013 err  output  1  load rejected.

Function
REQ-014 Frame format:
- 4-byte word count N;
- N words of 4 bytes each;
- 4-byte checksum equal to the XOR of all N words.
- All fields little-endian: the first byte goes to bits 7:0.
REQ-015 States:
- LEN: header.
- DATA: words.
- CHK: checksum.
- DONE: success.
- ERR: failure.
REQ-016 in_ready = 1 in LEN/DATA/CHK with reload low; 0 in DONE/ERR and in any cycle reload is high.
REQ-017 Byte counter:
- 2-bit; advances only on transfers.
- Wraps to 0 after the 4th byte.
- Gaps in in_valid never reset it.
REQ-018 LEN, 4th byte accepted:
- N == 0 -> CHK.
- N > 2^ADDR_W -> ERR.
- Otherwise -> DATA.
REQ-019 DATA, 4th byte of word k accepted:
- Next cycle: imem_we = 1 for exactly one cycle, imem_addr = k (k starts at 0), imem_wdata = assembled word.
- Running XOR updated with that word.
REQ-020 Full throughput at 1 byte/cycle; in_ready never drops inside a frame; back-to-back words give imem_we every 4th cycle.
REQ-021 After word N-1 is assembled -> CHK. imem_addr and imem_wdata hold their last values while imem_we is low.
REQ-022 CHK, 4th byte accepted: equal to running XOR -> DONE, else -> ERR.
REQ-023 DONE: done = 1, cpu_rstn = 1; both registered and asserted the cycle after the last checksum byte.
REQ-024 ERR: err = 1, cpu_rstn = 0.
REQ-025 reload in any state:
- Next state LEN; counters, word index and XOR cleared.
- done and err cleared; cpu_rstn driven 0 on the same edge.
- Words already written are not undone.
REQ-026 reload in the same cycle as in_valid: no transfer (in_ready low); the byte stays with the source.
REQ-027 cpu_rstn comes from a flop, so it is glitch-free.

Reset
REQ-028 rstn low asynchronously forces:
- state LEN, counters 0;
- imem_we 0, imem_addr 0, imem_wdata 0;
- cpu_rstn 0, done 0, err 0.
REQ-029 After rstn rises, in_ready = 1 (LEN).
REQ-030 rstn low mid-frame aborts the load; the source must restart the frame from the header.

Verification
REQ-031 Stream 03 00 00 00 | 93 02 00 00 | 13 03 00 00 | B7 F3 FF FF | 37 F2 FF FF with in_valid held high ->
- imem_we pulses at addr 0/1/2 with 00000293/00000313/FFFFF3B7, 4 cycles apart;
- done = 1 and cpu_rstn = 1 one cycle after the last byte;
- then in_ready = 0.
REQ-032 Same stream with checksum 00 00 00 00 -> three writes, then err = 1, cpu_rstn = 0, in_ready = 0. A reload pulse then returns to LEN with err = 0 and in_ready = 1.
REQ-033 Stream 00 00 00 00 | 00 00 00 00 -> no imem_we; done = 1.
REQ-034 ADDR_W = 10, header 01 04 00 00 (N = 1025) -> ERR the cycle after the 4th header byte; no imem_we.
REQ-035 Scenario REQ-031 with in_valid randomly low 50% of cycles -> identical write sequence and final done = 1.
REQ-036 Edge cases:
- rstn pulsed low after the 2nd write -> all outputs at reset values immediately; a full resend completes with done = 1.
- reload asserted in DATA -> state LEN; the next frame loads from addr 0.
